reorder_buffer: RTL and testbench
=================================

Name: reorder_buffer

Overview:
- Circular in-order reorder buffer of the out-of-order RV32I core.
- Decoder allocates one entry per cycle; the CDB marks entries done; the head retires in order.
- Retirement writes the register file, releases stores to the LSB, and detects branch mispredicts.
- Sits directly upstream of the register file: it drives the RF's dependency-rename, value-commit and flush inputs.

Parameters:
- ROB_SIZE_BIT, 3: index width; depth is ROB_SIZE = 2**ROB_SIZE_BIT = 8, taken from Config.v.

Ports:
- clk_in, input, 1: system clock.
- rst_in, input, 1: synchronous active-high reset.
- rdy_in, input, 1: when low, all state and registered outputs are held.
- issue_valid, input, 1: decoder allocates an entry this cycle.
- issue_type, input, 2: 0 REG, 1 STORE, 2 BRANCH, 3 EXIT.
- issue_rd, input, 5: destination register (REG and BRANCH/JAL link).
- issue_pc, input, 32: instruction PC.
- issue_pred_jump, input, 1: predictor decision (BRANCH only).
- issue_ready, input, 1: result already known at issue (LUI/AUIPC).
- issue_val, input, 32: result when issue_ready.
- rob_full, output, 1: count == ROB_SIZE.
- rob_tail, output, ROB_SIZE_BIT: id the next allocation receives.
- wb_valid, input, 1: CDB broadcast.
- wb_rob_id, input, ROB_SIZE_BIT: target entry.
- wb_val, input, 32: result.
- wb_jump, input, 1: actual branch outcome.
- wb_addr, input, 32: actual branch target.
- qry1_id / qry2_id, input, ROB_SIZE_BIT each: operand dependency lookup.
- qry1_ready / qry2_ready, output, 1 each: entry result available.
- qry1_val / qry2_val, output, 32 each: entry result.
- is_update_dep, output, 1: rename to RF.
- update_dep_id, output, 5: renamed register.
- update_dep, output, ROB_SIZE_BIT: producing entry id.
- is_update_val, output, 1: commit to RF.
- update_val_id, output, 5: committed register.
- update_val_dep, output, ROB_SIZE_BIT: committing entry id.
- update_val, output, 32: committed value.
- store_commit, output, 1: head store may write memory.
- store_rob_id, output, ROB_SIZE_BIT: id of that store.
- rob_clear, output, 1: flush pulse to RF/RS/LSB/decoder.
- clear_pc, output, 32: refetch PC.
- halt, output, 1: sticky; EXIT has retired.

Behaviour:
- Reset (at clock edge with rst_in high):
  - head, tail and count cleared to 0; all entry busy/ready bits cleared.
  - halt, rob_clear, is_update_val and store_commit = 0; every registered data output = 0.
- Allocation (combinational enable alloc = rdy_in && issue_valid && !rob_full && !rob_clear && !halt):
  - Entry[tail] is written at the edge: busy = 1, ready = issue_ready.
  - tail advances modulo ROB_SIZE.
  - An issue presented while rob_full is ignored; the decoder must hold it.
- Rename output is combinational: is_update_dep = alloc && (type REG or BRANCH), update_dep_id = issue_rd, update_dep = rob_tail. The RF latches it at the same edge.
- Writeback:
  - On wb_valid the target entry becomes ready, with value/jump/addr stored.
  - wb_valid on a non-busy entry is ignored.
- Query (combinational):
  - qryN_ready = entry ready, or (wb_valid && wb_rob_id == qryN_id).
  - Same-cycle CDB data takes priority over stored data.
- Commit (at most one per cycle, when count > 0 and entry[head] is ready):
  - All commit outputs are registered and valid in the cycle after the commit edge.
  - head advances and count decrements at the commit edge.
  - REG: is_update_val = 1, update_val_id = rd, update_val_dep = head id.
  - STORE: store_commit = 1, store_rob_id = head id.
  - BRANCH: write the link value as for REG. If wb_jump != pred_jump: rob_clear = 1, clear_pc = (wb_jump ? wb_addr : pc+4).
  - EXIT: halt = 1; no further commits or allocations until reset.
  - Pulse outputs return to 0 the next active cycle when there is no commit.
- Mispredict flush:
  - At the edge where rob_clear is set, head, tail and count are zeroed and all busy bits cleared.
  - A same-cycle allocation is discarded, and is_update_dep is forced to 0 while rob_clear = 1.
- Simultaneous events:
  - Allocation and commit in one edge leave count unchanged.
  - A writeback to the head entry is committable at the next edge, not the same one.
  - A full buffer that commits frees its slot one cycle later, since rob_full is derived from the registered count.
- Wrap-around: indices wrap with no gaps; count distinguishes full from empty when head == tail.
- rdy_in low: nothing updates; registered outputs keep their values; combinational enables are gated by rdy_in.

Decomposition:
- Config.v holds ROB_SIZE_BIT, ROB_SIZE and the ROB type encodings (ROB_REG, ROB_STORE, ROB_BRANCH, ROB_EXIT).
- Single module; entry storage is parallel reg arrays. No sub-module is warranted.

Test Plan:
- Reset, then issue REG rd=5 (tail 0) with wb val 0x1234 one cycle later:
  - is_update_dep pulses with id 5, dep 0, at issue.
  - Exactly one cycle of is_update_val, id 5, val 0x1234, update_val_dep 0.
- Issue 8 REGs without writeback:
  - rob_full = 1; a 9th issue is ignored and tail stays at 0.
  - Writeback id 0 leads to a commit, then rob_full = 0.
- BRANCH pc 0x100, pred 0, wb_jump 1, wb_addr 0x200, with 2 younger entries:
  - rob_clear pulses once, clear_pc = 0x200.
  - count = 0, and the next issue receives id 0.
- Query: wb_valid id 3 val 0xAB in the same cycle as qry1_id = 3 → qry1_ready = 1, qry1_val = 0xAB combinationally.
- Wrap-around across 20 issue/commit pairs → commits occur in issue order with ids 0..7,0..7,0..3.
- STORE then EXIT:
  - store_commit pulses with the store's id.
  - halt rises and stays high; later issues are ignored until rst_in.

Source files
------------

// File: rtl/reorder_buffer_pkg.sv
// Reorder buffer configuration and entry type encodings shared by the core.
package reorder_buffer_pkg;

  // Index width of the reorder buffer; depth is 2**ROB_SIZE_BIT.
  localparam int unsigned ROB_SIZE_BIT_DFLT = 3;

  // Kind of instruction held in a reorder buffer entry.
  typedef enum logic [1:0] {
    ROB_REG    = 2'd0,
    ROB_STORE  = 2'd1,
    ROB_BRANCH = 2'd2,
    ROB_EXIT   = 2'd3
  } rob_type_e;

  // Entry kinds that produce a destination register value (branches write the link).
  function automatic logic writes_rd(input rob_type_e t);
    return (t == ROB_REG) || (t == ROB_BRANCH);
  endfunction

  // Refetch address after a mispredicted branch.
  function automatic logic [31:0] redirect_pc(input logic        jump,
                                              input logic [31:0] target,
                                              input logic [31:0] pc);
    return jump ? target : pc + 32'd4;
  endfunction

endpackage

// File: rtl/reorder_buffer.sv
// Circular in-order reorder buffer: allocates one entry per cycle from the
// decoder, collects CDB results, and retires the head entry in order into the
// register file, the load/store buffer and the branch-recovery path.
module reorder_buffer
  import reorder_buffer_pkg::*;
#(
  parameter int unsigned ROB_SIZE_BIT = ROB_SIZE_BIT_DFLT
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    rdy_in,
  // allocation from the decoder
  input  logic                    issue_valid,
  input  logic [1:0]              issue_type,
  input  logic [4:0]              issue_rd,
  input  logic [31:0]             issue_pc,
  input  logic                    issue_pred_jump,
  input  logic                    issue_ready,
  input  logic [31:0]             issue_val,
  output logic                    rob_full,
  output logic [ROB_SIZE_BIT-1:0] rob_tail,
  // common data bus
  input  logic                    wb_valid,
  input  logic [ROB_SIZE_BIT-1:0] wb_rob_id,
  input  logic [31:0]             wb_val,
  input  logic                    wb_jump,
  input  logic [31:0]             wb_addr,
  // operand lookups
  input  logic [ROB_SIZE_BIT-1:0] qry1_id,
  output logic                    qry1_ready,
  output logic [31:0]             qry1_val,
  input  logic [ROB_SIZE_BIT-1:0] qry2_id,
  output logic                    qry2_ready,
  output logic [31:0]             qry2_val,
  // register file rename
  output logic                    is_update_dep,
  output logic [4:0]              update_dep_id,
  output logic [ROB_SIZE_BIT-1:0] update_dep,
  // register file commit
  output logic                    is_update_val,
  output logic [4:0]              update_val_id,
  output logic [ROB_SIZE_BIT-1:0] update_val_dep,
  output logic [31:0]             update_val,
  // store release
  output logic                    store_commit,
  output logic [ROB_SIZE_BIT-1:0] store_rob_id,
  // mispredict recovery and halt
  output logic                    rob_clear,
  output logic [31:0]             clear_pc,
  output logic                    halt
);

  localparam int unsigned ROB_SIZE = 1 << ROB_SIZE_BIT;

  typedef logic [ROB_SIZE_BIT-1:0] rob_id_t;
  typedef logic [ROB_SIZE_BIT:0]   rob_cnt_t;

  localparam rob_cnt_t COUNT_FULL = {1'b1, {ROB_SIZE_BIT{1'b0}}};

  // Ring pointers and occupancy; count tells full from empty when head == tail.
  rob_id_t  head_q;
  rob_id_t  tail_q;
  rob_cnt_t count_q;

  // Per-entry status bits (reset) and payload (not reset).
  logic [ROB_SIZE-1:0] busy_q;
  logic [ROB_SIZE-1:0] ready_q;
  rob_type_e           type_q [ROB_SIZE];
  logic [4:0]          rd_q   [ROB_SIZE];
  logic [31:0]         pc_q   [ROB_SIZE];
  logic [31:0]         val_q  [ROB_SIZE];
  logic [31:0]         addr_q [ROB_SIZE];
  logic [ROB_SIZE-1:0] pred_q;
  logic [ROB_SIZE-1:0] jump_q;

  logic      alloc;
  logic      wb_write;
  logic      commit;
  rob_type_e head_type;
  logic      head_mispredict;

  // Allocation is refused while full, while a flush is in flight and after halt.
  assign alloc = rdy_in && issue_valid && !rob_full && !rob_clear && !halt;

  // A CDB result is only recorded for a live entry; a flush discards it.
  assign wb_write = rdy_in && !rob_clear && wb_valid && busy_q[wb_rob_id];

  // Retire uses the registered ready bit, so a same-cycle writeback to the
  // head waits one edge.
  assign commit = rdy_in && !rob_clear && !halt && (count_q != '0) && ready_q[head_q];

  assign head_type       = type_q[head_q];
  assign head_mispredict = (head_type == ROB_BRANCH) && (jump_q[head_q] != pred_q[head_q]);

  assign rob_full = (count_q == COUNT_FULL);
  assign rob_tail = tail_q;

  // Rename goes straight to the register file, which latches it at this edge.
  assign is_update_dep = alloc && writes_rd(rob_type_e'(issue_type));
  assign update_dep_id = issue_rd;
  assign update_dep    = tail_q;

  // Operand lookups forward a same-cycle CDB result ahead of stored data; the
  // bus value is not yet in the entry, so the forward is not gated by rdy_in.
  logic qry1_hit;
  logic qry2_hit;
  assign qry1_hit   = wb_valid && (wb_rob_id == qry1_id);
  assign qry2_hit   = wb_valid && (wb_rob_id == qry2_id);
  assign qry1_ready = ready_q[qry1_id] || qry1_hit;
  assign qry2_ready = ready_q[qry2_id] || qry2_hit;
  assign qry1_val   = qry1_hit ? wb_val : val_q[qry1_id];
  assign qry2_val   = qry2_hit ? wb_val : val_q[qry2_id];

  // Entry payload: written on allocation and on CDB writeback.
  // NOTE: payload arrays carry no reset; busy/ready gate every use of them,
  // so resetting them would only cost reset fan-out.
  always_ff @(posedge clk_in) begin
    if (wb_write) begin
      val_q[wb_rob_id]  <= wb_val;
      jump_q[wb_rob_id] <= wb_jump;
      addr_q[wb_rob_id] <= wb_addr;
    end
    if (alloc) begin
      type_q[tail_q] <= rob_type_e'(issue_type);
      rd_q[tail_q]   <= issue_rd;
      pc_q[tail_q]   <= issue_pc;
      pred_q[tail_q] <= issue_pred_jump;
      val_q[tail_q]  <= issue_val;
      // A branch resolved at issue never flags a mispredict by itself.
      jump_q[tail_q] <= issue_pred_jump;
      addr_q[tail_q] <= '0;
    end
  end

  // Ring control, entry status bits and the registered retirement outputs.
  // NOTE: sequential state uses non-blocking assignments only, so every read
  // in this block sees the pre-edge value and statement order does not matter
  // except where a later assignment deliberately overrides an earlier default.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      busy_q         <= '0;
      ready_q        <= '0;
      halt           <= 1'b0;
      rob_clear      <= 1'b0;
      is_update_val  <= 1'b0;
      store_commit   <= 1'b0;
      update_val_id  <= '0;
      update_val_dep <= '0;
      update_val     <= '0;
      store_rob_id   <= '0;
      clear_pc       <= '0;
    end else if (rdy_in) begin
      is_update_val <= 1'b0;
      store_commit  <= 1'b0;
      rob_clear     <= 1'b0;
      if (rob_clear) begin
        // Flush: every younger entry is squashed and the ring restarts at 0.
        head_q  <= '0;
        tail_q  <= '0;
        count_q <= '0;
        busy_q  <= '0;
        ready_q <= '0;
      end else begin
        if (wb_write) begin
          ready_q[wb_rob_id] <= 1'b1;
        end

        if (commit) begin
          busy_q[head_q]  <= 1'b0;
          ready_q[head_q] <= 1'b0;
          head_q          <= head_q + rob_id_t'(1);
          case (head_type)
            ROB_REG: begin
              is_update_val  <= 1'b1;
              update_val_id  <= rd_q[head_q];
              update_val_dep <= head_q;
              update_val     <= val_q[head_q];
            end
            ROB_STORE: begin
              store_commit <= 1'b1;
              store_rob_id <= head_q;
            end
            ROB_BRANCH: begin
              is_update_val  <= 1'b1;
              update_val_id  <= rd_q[head_q];
              update_val_dep <= head_q;
              update_val     <= val_q[head_q];
              if (head_mispredict) begin
                rob_clear <= 1'b1;
                clear_pc  <= redirect_pc(jump_q[head_q], addr_q[head_q], pc_q[head_q]);
              end
            end
            ROB_EXIT: begin
              halt <= 1'b1;
            end
          endcase
        end

        if (alloc) begin
          busy_q[tail_q]  <= 1'b1;
          ready_q[tail_q] <= issue_ready;
          tail_q          <= tail_q + rob_id_t'(1);
        end

        if (alloc && !commit) begin
          count_q <= count_q + rob_cnt_t'(1);
        end else if (!alloc && commit) begin
          count_q <= count_q - rob_cnt_t'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: a queue-based reference model is
// compared against the DUT every cycle, plus directed literal expectations.
module tb_reorder_buffer;
  import reorder_buffer_pkg::*;

  localparam int RS = 8;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in;
  logic        issue_valid;
  logic [1:0]  issue_type;
  logic [4:0]  issue_rd;
  logic [31:0] issue_pc;
  logic        issue_pred_jump, issue_ready;
  logic [31:0] issue_val;
  logic        rob_full;
  logic [2:0]  rob_tail;
  logic        wb_valid;
  logic [2:0]  wb_rob_id;
  logic [31:0] wb_val;
  logic        wb_jump;
  logic [31:0] wb_addr;
  logic [2:0]  qry1_id, qry2_id;
  logic        qry1_ready, qry2_ready;
  logic [31:0] qry1_val, qry2_val;
  logic        is_update_dep;
  logic [4:0]  update_dep_id;
  logic [2:0]  update_dep;
  logic        is_update_val;
  logic [4:0]  update_val_id;
  logic [2:0]  update_val_dep;
  logic [31:0] update_val;
  logic        store_commit;
  logic [2:0]  store_rob_id;
  logic        rob_clear;
  logic [31:0] clear_pc;
  logic        halt;

  reorder_buffer #(.ROB_SIZE_BIT(3)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .issue_valid(issue_valid), .issue_type(issue_type), .issue_rd(issue_rd),
    .issue_pc(issue_pc), .issue_pred_jump(issue_pred_jump),
    .issue_ready(issue_ready), .issue_val(issue_val),
    .rob_full(rob_full), .rob_tail(rob_tail),
    .wb_valid(wb_valid), .wb_rob_id(wb_rob_id), .wb_val(wb_val),
    .wb_jump(wb_jump), .wb_addr(wb_addr),
    .qry1_id(qry1_id), .qry1_ready(qry1_ready), .qry1_val(qry1_val),
    .qry2_id(qry2_id), .qry2_ready(qry2_ready), .qry2_val(qry2_val),
    .is_update_dep(is_update_dep), .update_dep_id(update_dep_id), .update_dep(update_dep),
    .is_update_val(is_update_val), .update_val_id(update_val_id),
    .update_val_dep(update_val_dep), .update_val(update_val),
    .store_commit(store_commit), .store_rob_id(store_rob_id),
    .rob_clear(rob_clear), .clear_pc(clear_pc), .halt(halt)
  );

  always #5 clk_in = ~clk_in;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int          id;
    int          typ;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic        pred;
    logic        ready;
    logic [31:0] val;
    logic        jump;
    logic [31:0] addr;
  } ent_t;

  ent_t        mq[$];          // live entries, oldest first
  int          m_tail;
  bit          m_halt, m_clear, m_uval, m_store;
  logic [4:0]  m_uval_id;
  int          m_uval_dep, m_store_id;
  logic [31:0] m_uval_v, m_clear_pc;
  bit          cmp_en = 1'b0;

  bit   m_do_alloc, m_do_commit;
  ent_t m_head, m_new;

  function automatic void model_reset();
    mq.delete();
    m_tail = 0; m_halt = 0; m_clear = 0; m_uval = 0; m_store = 0;
    m_uval_id = 0; m_uval_dep = 0; m_store_id = 0; m_uval_v = 0; m_clear_pc = 0;
  endfunction

  always @(posedge clk_in) begin
    if (rst_in) begin
      model_reset();
    end else if (rdy_in) begin
      if (m_clear) begin
        mq.delete();
        m_tail = 0; m_clear = 0; m_uval = 0; m_store = 0;
      end else begin
        m_do_alloc  = issue_valid && (mq.size() < RS) && !m_halt;
        m_do_commit = !m_halt && (mq.size() > 0) && mq[0].ready;
        if (m_do_commit) m_head = mq[0];
        if (wb_valid)
          foreach (mq[k])
            if (mq[k].id == int'(wb_rob_id)) begin
              mq[k].ready = 1; mq[k].val = wb_val; mq[k].jump = wb_jump; mq[k].addr = wb_addr;
            end
        m_uval = 0; m_store = 0;
        if (m_do_commit) begin
          void'(mq.pop_front());
          if (m_head.typ == 0 || m_head.typ == 2) begin
            m_uval = 1; m_uval_id = m_head.rd; m_uval_dep = m_head.id; m_uval_v = m_head.val;
          end
          if (m_head.typ == 1) begin
            m_store = 1; m_store_id = m_head.id;
          end
          if (m_head.typ == 2 && m_head.jump != m_head.pred) begin
            m_clear = 1;
            m_clear_pc = m_head.jump ? m_head.addr : m_head.pc + 32'd4;
          end
          if (m_head.typ == 3) m_halt = 1;
        end
        if (m_do_alloc) begin
          m_new.id = m_tail; m_new.typ = int'(issue_type); m_new.rd = issue_rd;
          m_new.pc = issue_pc; m_new.pred = issue_pred_jump; m_new.ready = issue_ready;
          m_new.val = issue_val; m_new.jump = issue_pred_jump; m_new.addr = 0;
          mq.push_back(m_new);
          m_tail = (m_tail + 1) % RS;
        end
      end
    end
  end

  function automatic void q_expect(input logic [2:0] id, output logic rdy, output logic [31:0] v);
    rdy = 0; v = 0;
    foreach (mq[k]) if (mq[k].id == int'(id) && mq[k].ready) begin rdy = 1; v = mq[k].val; end
    if (wb_valid && wb_rob_id == id) begin rdy = 1; v = wb_val; end
  endfunction

  logic        e_alloc, e_dep, e_q1r, e_q2r;
  logic [31:0] e_q1v, e_q2v;

  // Per-cycle comparison of every output against the model.
  always @(negedge clk_in) begin
    if (cmp_en) begin
      e_alloc = rdy_in && issue_valid && (mq.size() < RS) && !m_clear && !m_halt;
      e_dep   = e_alloc && (issue_type == 2'd0 || issue_type == 2'd2);
      check("rob_full", rob_full, mq.size() == RS);
      check("rob_tail", rob_tail, m_tail);
      check("is_update_dep", is_update_dep, e_dep);
      if (e_dep) begin
        check("update_dep_id", update_dep_id, issue_rd);
        check("update_dep", update_dep, m_tail);
      end
      check("is_update_val", is_update_val, m_uval);
      check("update_val_id", update_val_id, m_uval_id);
      check("update_val_dep", update_val_dep, m_uval_dep);
      check("update_val", update_val, m_uval_v);
      check("store_commit", store_commit, m_store);
      check("store_rob_id", store_rob_id, m_store_id);
      check("rob_clear", rob_clear, m_clear);
      check("clear_pc", clear_pc, m_clear_pc);
      check("halt", halt, m_halt);
      q_expect(qry1_id, e_q1r, e_q1v);
      q_expect(qry2_id, e_q2r, e_q2v);
      check("qry1_ready", qry1_ready, e_q1r);
      check("qry2_ready", qry2_ready, e_q2r);
      if (e_q1r) check("qry1_val", qry1_val, e_q1v);
      if (e_q2r) check("qry2_val", qry2_val, e_q2v);
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle_inputs();
    issue_valid = 0; issue_type = 0; issue_rd = 0; issue_pc = 0;
    issue_pred_jump = 0; issue_ready = 0; issue_val = 0;
    wb_valid = 0; wb_rob_id = 0; wb_val = 0; wb_jump = 0; wb_addr = 0;
    qry1_id = 0; qry2_id = 0;
  endtask

  task automatic cyc();
    @(posedge clk_in);
    @(negedge clk_in);
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rdy_in = 1; rst_in = 1;
    cyc(); cyc();
    rst_in = 0;
  endtask

  task automatic put_issue(input int t, input int rd, input logic [31:0] pc,
                           input bit pred, input bit rdy, input logic [31:0] v);
    issue_valid = 1; issue_type = 2'(t); issue_rd = 5'(rd); issue_pc = pc;
    issue_pred_jump = pred; issue_ready = rdy; issue_val = v;
  endtask

  task automatic put_wb(input int id, input logic [31:0] v, input bit j, input logic [31:0] a);
    wb_valid = 1; wb_rob_id = 3'(id); wb_val = v; wb_jump = j; wb_addr = a;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_in = 1; rdy_in = 1; idle_inputs();
    do_reset();
    cmp_en = 1;

    // Reset state
    check("reset rob_tail", rob_tail, 0);
    check("reset rob_full", rob_full, 0);
    check("reset halt", halt, 0);
    check("reset rob_clear", rob_clear, 0);
    check("reset is_update_val", is_update_val, 0);
    check("reset update_val", update_val, 0);
    check("reset clear_pc", clear_pc, 0);

    // Single REG: rename at issue, one commit pulse after writeback
    put_issue(0, 5, 32'h40, 0, 0, 0);
    #1;
    check("t1 is_update_dep", is_update_dep, 1);
    check("t1 update_dep_id", update_dep_id, 5);
    check("t1 update_dep", update_dep, 0);
    cyc(); idle_inputs();
    put_wb(0, 32'h1234, 0, 0);
    cyc(); idle_inputs();
    check("t1 no early commit", is_update_val, 0);
    cyc();
    check("t1 is_update_val", is_update_val, 1);
    check("t1 update_val_id", update_val_id, 5);
    check("t1 update_val", update_val, 32'h1234);
    check("t1 update_val_dep", update_val_dep, 0);
    cyc();
    check("t1 pulse ends", is_update_val, 0);

    // Fill to full, ignored 9th issue, commit frees a slot
    do_reset();
    for (int i = 0; i < 8; i++) begin
      put_issue(0, i + 1, 32'h100 + 32'(4 * i), 0, 0, 0);
      cyc(); idle_inputs();
    end
    check("t2 rob_full", rob_full, 1);
    check("t2 rob_tail", rob_tail, 0);
    put_issue(0, 9, 32'h200, 0, 0, 0);
    #1;
    check("t2 9th no rename", is_update_dep, 0);
    cyc(); idle_inputs();
    check("t2 tail held", rob_tail, 0);
    put_wb(0, 32'h55, 0, 0);
    cyc(); idle_inputs();
    check("t2 still full", rob_full, 1);
    cyc();
    check("t2 commit", is_update_val, 1);
    check("t2 commit dep", update_val_dep, 0);
    check("t2 freed", rob_full, 0);

    // Mispredicted branch with two younger entries
    do_reset();
    put_issue(2, 1, 32'h100, 0, 0, 0); cyc(); idle_inputs();
    put_issue(0, 2, 32'h104, 0, 0, 0); cyc(); idle_inputs();
    put_issue(0, 3, 32'h108, 0, 0, 0); cyc(); idle_inputs();
    put_wb(0, 32'h104, 1, 32'h200);
    cyc(); idle_inputs();
    check("t3 no clear yet", rob_clear, 0);
    cyc();
    check("t3 rob_clear", rob_clear, 1);
    check("t3 clear_pc", clear_pc, 32'h200);
    check("t3 link write", update_val, 32'h104);
    put_issue(0, 7, 32'h300, 0, 0, 0);
    #1;
    check("t3 rename blocked", is_update_dep, 0);
    cyc(); idle_inputs();
    check("t3 clear once", rob_clear, 0);
    check("t3 tail 0", rob_tail, 0);
    put_issue(0, 4, 32'h200, 0, 0, 0);
    #1;
    check("t3 next id", update_dep, 0);
    cyc(); idle_inputs();

    // Query forwarding
    do_reset();
    for (int i = 0; i < 4; i++) begin
      put_issue(0, i + 1, 32'(i * 4), 0, 0, 0);
      cyc(); idle_inputs();
    end
    put_wb(3, 32'hAB, 0, 0); qry1_id = 3; qry2_id = 2;
    #1;
    check("t4 qry1_ready", qry1_ready, 1);
    check("t4 qry1_val", qry1_val, 32'hAB);
    check("t4 qry2_ready", qry2_ready, 0);
    cyc(); idle_inputs();
    qry1_id = 3;
    #1;
    check("t4 stored val", qry1_val, 32'hAB);
    put_wb(3, 32'hCD, 0, 0);
    #1;
    check("t4 bus priority", qry1_val, 32'hCD);
    cyc(); idle_inputs();

    // Wrap-around: 20 back-to-back issue/commit pairs
    do_reset();
    for (int i = 0; i <= 20; i++) begin
      if (i < 20) put_issue(0, (i % 31) + 1, 32'(i * 4), 0, 1, 32'(i));
      cyc(); idle_inputs();
      if (i > 0) begin
        check("t5 commit", is_update_val, 1);
        check("t5 order id", update_val_dep, 32'((i - 1) % 8));
        check("t5 order val", update_val, 32'(i - 1));
      end
    end

    // STORE then EXIT
    do_reset();
    put_issue(1, 0, 32'h500, 0, 1, 0); cyc(); idle_inputs();
    put_issue(3, 0, 32'h504, 0, 1, 0); cyc(); idle_inputs();
    check("t6 store_commit", store_commit, 1);
    check("t6 store_rob_id", store_rob_id, 0);
    cyc();
    check("t6 halt", halt, 1);
    check("t6 store pulse ends", store_commit, 0);
    put_issue(0, 6, 32'h508, 0, 0, 0);
    #1;
    check("t6 issue blocked", is_update_dep, 0);
    cyc(); idle_inputs();
    check("t6 tail held", rob_tail, 2);
    cyc();
    check("t6 halt sticky", halt, 1);
    do_reset();
    check("t6 halt cleared", halt, 0);

    // Randomized traffic against the model
    for (int c = 0; c < 2000; c++) begin
      int r;
      int k;
      idle_inputs();
      rdy_in = ($urandom_range(0, 7) != 0);
      if (m_halt && $urandom_range(0, 3) == 0) rst_in = 1;
      else rst_in = ($urandom_range(0, 399) == 0);
      if ($urandom_range(0, 2) != 0) begin
        r = $urandom_range(0, 63);
        issue_valid     = 1;
        issue_type      = (r < 30) ? 2'd0 : (r < 45) ? 2'd1 : (r < 63) ? 2'd2 : 2'd3;
        issue_rd        = 5'($urandom);
        issue_pc        = $urandom & 32'hFFFF_FFFC;
        issue_pred_jump = 1'($urandom);
        issue_ready     = ($urandom_range(0, 3) == 0);
        issue_val       = $urandom;
      end
      if (mq.size() > 0 && $urandom_range(0, 1) == 1) begin
        k = $urandom_range(0, mq.size() - 1);
        put_wb(mq[k].id, $urandom, 1'($urandom), $urandom & 32'hFFFF_FFFC);
      end else if ($urandom_range(0, 9) == 0) begin
        put_wb($urandom_range(0, 7), $urandom, 1'($urandom), $urandom);
      end
      qry1_id = 3'($urandom);
      qry2_id = 3'($urandom);
      cyc();
    end

    rst_in = 0; rdy_in = 1; idle_inputs();
    cyc(); cyc();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
